devil_attack_scheduler: RTL and testbench

Sequences the active-path attack engine (ADL/ADT read/write snoop issuer) on behalf of two requesters: the software command path (AXI-Lite registers) and the passive snoop path (snoop-matching logic). Requests {func, addr} are round-robin arbitrated into a shared FIFO. Entries are then launched one at a time: assert the trigger, wait for end-of-operation, release the trigger, wait for the engine to re-arm. Adds a per-operation timeout and completion reporting.

---
 rtl/devil_attack_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_devil_attack_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/devil_attack_scheduler.sv
// Arbitrates software and snoop attack requests into a small FIFO and launches them
// one at a time on the attack engine: trigger, wait for end (or timeout), release, re-arm.
module devil_attack_scheduler #(
    parameter int          C_ACE_ADDR_WIDTH = 44,
    parameter int          FIFO_DEPTH       = 4,
    parameter int          TIMEOUT_W        = 16,
    parameter logic [3:0]  C_FUNC_ADL       = 4'h1,
    parameter logic [3:0]  C_FUNC_ADT       = 4'h2
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic                          i_en,
    input  logic                          i_sw_req_valid,
    output logic                          o_sw_req_ready,
    input  logic [3:0]                    i_sw_func,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_sw_addr,
    input  logic                          i_snp_req_valid,
    output logic                          o_snp_req_ready,
    input  logic [3:0]                    i_snp_func,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_snp_addr,
    input  logic                          i_end,
    input  logic                          i_busy,
    input  logic [TIMEOUT_W-1:0]          i_timeout_cycles,
    output logic                          o_trigger_active,
    output logic [3:0]                    o_func,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_addr,
    output logic                          o_internal_adl_en,
    output logic                          o_internal_adt_en,
    output logic                          o_done_valid,
    output logic                          o_done_src,
    output logic                          o_done_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [TIMEOUT_W-1:0]          o_timeout_cnt,
    output logic [2:0]                    o_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 1 + 4 + C_ACE_ADDR_WIDTH;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_END  = 3'd2,
        S_RELEASE   = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    // Valid/ready: a request is transferred on a clock edge where valid and ready are both
    // high; ready depends only on enable, FIFO level, both valids and the rr pointer.
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ENT_W-1:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]        r_level;
    logic                    r_rr_snp;
    logic                    r_src_q;
    logic [3:0]              r_func;
    logic [C_ACE_ADDR_WIDTH-1:0] r_addr;
    logic                    r_trigger;
    logic                    r_done_valid;
    logic                    r_done_src;
    logic                    r_done_timeout;
    logic [TIMEOUT_W-1:0]    r_timer;
    logic [TIMEOUT_W-1:0]    r_timeout_cnt;

    logic                    w_both;
    logic                    w_grant_sw;
    logic                    w_grant_snp;
    logic                    w_can_push;
    logic                    w_push;
    logic                    w_pop;
    logic [ENT_W-1:0]        w_push_data;
    logic [ENT_W-1:0]        w_head;
    logic                    w_tmo_expired;
    logic                    w_timeout_hit;

    assign w_both      = i_sw_req_valid && i_snp_req_valid;
    assign w_grant_sw  = i_sw_req_valid  && (!i_snp_req_valid || !r_rr_snp);
    assign w_grant_snp = i_snp_req_valid && (!i_sw_req_valid  ||  r_rr_snp);
    assign w_can_push  = i_en && (r_level < LVL_FULL);

    assign o_sw_req_ready  = w_can_push && w_grant_sw;
    assign o_snp_req_ready = w_can_push && w_grant_snp;

    assign w_push      = o_sw_req_ready || o_snp_req_ready;
    assign w_push_data = w_grant_snp ? {1'b1, i_snp_func, i_snp_addr}
                                     : {1'b0, i_sw_func,  i_sw_addr};
    assign w_head      = r_mem[r_rd_ptr];

    // Pop only when the engine is fully re-armed; pop never feeds back into ready.
    assign w_pop = (r_state == S_IDLE) && i_en && (r_level != '0) && !i_busy && !i_end;

    assign w_tmo_expired = (i_timeout_cycles != '0) &&
                           (r_timer == (i_timeout_cycles - TIMEOUT_W'(1)));

    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (i_end) begin
                    w_state_nxt = S_RELEASE;
                end else if (w_tmo_expired) begin
                    w_state_nxt   = S_RELEASE;
                    w_timeout_hit = 1'b1;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!i_busy && !i_end) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge ace_aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_rr_snp       <= 1'b0;
            r_src_q        <= 1'b0;
            r_func         <= '0;
            r_addr         <= '0;
            r_trigger      <= 1'b0;
            r_done_valid   <= 1'b0;
            r_done_src     <= 1'b0;
            r_done_timeout <= 1'b0;
            r_timer        <= '0;
            r_timeout_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
            else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);

            if (w_push && w_both) r_rr_snp <= ~r_rr_snp;

            if (w_pop) begin
                r_src_q <= w_head[ENT_W-1];
                r_func  <= w_head[C_ACE_ADDR_WIDTH +: 4];
                r_addr  <= w_head[C_ACE_ADDR_WIDTH-1:0];
            end

            r_trigger    <= (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_WAIT_END);
            r_done_valid <= (w_state_nxt == S_RELEASE);
            if (w_state_nxt == S_RELEASE) begin
                r_done_src     <= r_src_q;
                r_done_timeout <= w_timeout_hit;
            end

            if (r_state == S_LAUNCH)        r_timer <= '0;
            else if (r_state == S_WAIT_END) r_timer <= r_timer + TIMEOUT_W'(1);

            if (w_timeout_hit && (r_timeout_cnt != '1))
                r_timeout_cnt <= r_timeout_cnt + TIMEOUT_W'(1);
        end
    end

    assign o_trigger_active  = r_trigger;
    assign o_func            = r_func;
    assign o_addr            = r_addr;
    assign o_internal_adl_en = r_trigger && (r_func == C_FUNC_ADL);
    assign o_internal_adt_en = r_trigger && (r_func == C_FUNC_ADT);
    assign o_done_valid      = r_done_valid;
    assign o_done_src        = r_done_src;
    assign o_done_timeout    = r_done_timeout;
    assign o_fifo_level      = r_level;
    assign o_timeout_cnt     = r_timeout_cnt;
    assign o_state           = r_state;

endmodule

// File: tb/tb_devil_attack_scheduler.sv
// Bench for devil_attack_scheduler: behavioural engine model, launch-order scoreboard,
// table of single-op vectors and hand sequences for fill, contention, timeout and reset.
module tb_devil_attack_scheduler;
  localparam int AW    = 44;
  localparam int DEPTH = 4;
  localparam int TW    = 16;
  localparam int EW    = 1 + 4 + AW;
  localparam logic [3:0] F_ADL = 4'h1;
  localparam logic [3:0] F_ADT = 4'h2;
  localparam logic [3:0] F_OTH = 4'h5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_en = 1'b0;
  logic          i_sw_req_valid = 1'b0;
  logic          o_sw_req_ready;
  logic [3:0]    i_sw_func = '0;
  logic [AW-1:0] i_sw_addr = '0;
  logic          i_snp_req_valid = 1'b0;
  logic          o_snp_req_ready;
  logic [3:0]    i_snp_func = '0;
  logic [AW-1:0] i_snp_addr = '0;
  logic          i_end = 1'b0;
  logic          i_busy = 1'b0;
  logic [TW-1:0] i_timeout_cycles = '0;
  logic          o_trigger_active;
  logic [3:0]    o_func;
  logic [AW-1:0] o_addr;
  logic          o_internal_adl_en;
  logic          o_internal_adt_en;
  logic          o_done_valid;
  logic          o_done_src;
  logic          o_done_timeout;
  logic [2:0]    o_fifo_level;
  logic [TW-1:0] o_timeout_cnt;
  logic [2:0]    o_state;

  devil_attack_scheduler #(
    .C_ACE_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT_W(TW),
    .C_FUNC_ADL(F_ADL), .C_FUNC_ADT(F_ADT)
  ) dut (
    .ace_aclk(clk), .ace_areset(rst), .i_en(i_en),
    .i_sw_req_valid(i_sw_req_valid), .o_sw_req_ready(o_sw_req_ready),
    .i_sw_func(i_sw_func), .i_sw_addr(i_sw_addr),
    .i_snp_req_valid(i_snp_req_valid), .o_snp_req_ready(o_snp_req_ready),
    .i_snp_func(i_snp_func), .i_snp_addr(i_snp_addr),
    .i_end(i_end), .i_busy(i_busy), .i_timeout_cycles(i_timeout_cycles),
    .o_trigger_active(o_trigger_active), .o_func(o_func), .o_addr(o_addr),
    .o_internal_adl_en(o_internal_adl_en), .o_internal_adt_en(o_internal_adt_en),
    .o_done_valid(o_done_valid), .o_done_src(o_done_src), .o_done_timeout(o_done_timeout),
    .o_fifo_level(o_fifo_level), .o_timeout_cnt(o_timeout_cnt), .o_state(o_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- engine model ----------------
  // eng_delay: cycles after trigger seen before i_end (<0 never); eng_drain: busy tail.
  int eng_delay = 0;
  int eng_drain = 0;
  bit eng_hold  = 1'b0;
  int eng_cnt   = 0;
  int drain_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      i_end = 1'b0; i_busy = 1'b0; eng_cnt = 0; drain_cnt = 0;
    end else if (o_trigger_active) begin
      i_busy = 1'b1;
      drain_cnt = eng_drain;
      if (eng_delay >= 0 && eng_cnt >= eng_delay) i_end = 1'b1;
      eng_cnt++;
    end else begin
      eng_cnt = 0;
      i_end = 1'b0;
      if (drain_cnt > 0) drain_cnt--;
      else i_busy = eng_hold;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  logic          src_q[$];
  logic          prev_trig = 1'b0;
  int            wait_cnt = 0;
  int            trig_cnt = 0;
  int            done_cnt = 0;
  bit            seen_adl = 1'b0;
  bit            seen_adt = 1'b0;

  always @(negedge clk) begin : monitor
    logic [EW-1:0] item;
    logic          s;
    if (rst) begin
      exp_q.delete();
      src_q.delete();
      prev_trig = 1'b0;
    end else begin
      if (i_sw_req_valid && o_sw_req_ready)   exp_q.push_back({1'b0, i_sw_func, i_sw_addr});
      if (i_snp_req_valid && o_snp_req_ready) exp_q.push_back({1'b1, i_snp_func, i_snp_addr});
      if (o_trigger_active && !prev_trig) begin
        seen_adl = 1'b0;
        seen_adt = 1'b0;
        if (exp_q.size() == 0) begin
          check("launch_without_request", 64'(o_trigger_active), 64'd0);
        end else begin
          item = exp_q.pop_front();
          check("launch_func", 64'(o_func), 64'(item[AW +: 4]));
          check("launch_addr", 64'(o_addr), 64'(item[AW-1:0]));
          src_q.push_back(item[EW-1]);
        end
      end
      if (o_trigger_active) begin
        trig_cnt++;
        seen_adl = seen_adl | o_internal_adl_en;
        seen_adt = seen_adt | o_internal_adt_en;
      end
      if (o_state == 3'd2) wait_cnt++;
      if (o_done_valid) begin
        done_cnt++;
        if (src_q.size() == 0) begin
          check("done_without_launch", 64'(o_done_valid), 64'd0);
        end else begin
          s = src_q.pop_front();
          check("done_src", 64'(o_done_src), 64'(s));
        end
      end
      prev_trig = o_trigger_active;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic send(input bit snp, input logic [3:0] f, input logic [AW-1:0] a);
    int n;
    bit got;
    n = 0;
    if (snp) begin i_snp_req_valid = 1'b1; i_snp_func = f; i_snp_addr = a; end
    else     begin i_sw_req_valid  = 1'b1; i_sw_func  = f; i_sw_addr  = a; end
    do begin
      @(negedge clk); n++;
      got = snp ? o_snp_req_ready : o_sw_req_ready;
    end while (!got && n < 300);
    check("accept_bound", 64'(got), 64'd1);
    @(posedge clk); #1;
    if (snp) i_snp_req_valid = 1'b0; else i_sw_req_valid = 1'b0;
  endtask

  // Returns at the negedge carrying the done pulse.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_done_valid && n < 400);
    check(name, 64'(o_done_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (o_state != 3'd0 && n < 400);
    check("return_to_idle", 64'(o_state), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit            snp;
    logic [3:0]    func;
    logic [AW-1:0] addr;
    int            delay;
    logic [TW-1:0] tmo;
    bit            exp_to;
    int            exp_wait;
    bit            exp_adl;
    bit            exp_adt;
  } vec_t;

  vec_t vecs[8];
  int   exp_tcnt = 0;

  initial begin
    int w0, t0, d0, n;
    bit exp_snp;
    vecs[0] = '{1'b0, F_ADT, 44'h1_2345_6780,  2, 16'd0, 1'b0,  2, 1'b0, 1'b1};
    vecs[1] = '{1'b1, F_ADL, 44'h0000_0ABC0,   0, 16'd0, 1'b0,  1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, F_OTH, 44'h40,           5, 16'd0, 1'b0,  5, 1'b0, 1'b0};
    vecs[3] = '{1'b1, F_ADL, 44'h800,         -1, 16'd8, 1'b1,  8, 1'b1, 1'b0};
    vecs[4] = '{1'b0, F_ADT, 44'h880,          8, 16'd8, 1'b0,  8, 1'b0, 1'b1};
    vecs[5] = '{1'b1, F_ADT, 44'h900,          7, 16'd8, 1'b0,  7, 1'b0, 1'b1};
    vecs[6] = '{1'b0, F_ADL, 44'hFFF_FFFF_FFC0, 30, 16'd0, 1'b0, 30, 1'b1, 1'b0};
    vecs[7] = '{1'b0, F_ADL, 44'h0,           -1, 16'd1, 1'b1,  1, 1'b1, 1'b0};

    // ---- reset state ----
    #12;
    check("rst_trigger", 64'(o_trigger_active), 64'd0);
    check("rst_level",   64'(o_fifo_level), 64'd0);
    check("rst_state",   64'(o_state), 64'd0);
    check("rst_done",    64'(o_done_valid), 64'd0);
    check("rst_func_addr", {16'(o_func), 48'(o_addr)}, 64'd0);
    do_reset();
    i_en = 1'b1;

    // ---- single ADL op: accept-to-trigger latency, end 10 cycles later ----
    eng_delay = 10;
    t0 = trig_cnt;
    i_sw_req_valid = 1'b1; i_sw_func = F_ADL; i_sw_addr = 44'h1000;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_sw_req_ready && n < 50);
    check("lat_accept", 64'(o_sw_req_ready), 64'd1);
    @(posedge clk); #1; i_sw_req_valid = 1'b0;
    @(negedge clk);
    check("lat_trig_cycle1", 64'(o_trigger_active), 64'd0);
    @(negedge clk);
    check("lat_trig_cycle2", 64'(o_trigger_active), 64'd1);
    check("lat_adl_en", 64'(o_internal_adl_en), 64'd1);
    wait_done("lat_done");
    check("lat_done_src", 64'(o_done_src), 64'd0);
    check("lat_done_timeout", 64'(o_done_timeout), 64'd0);
    check("lat_trigger_high_cycles", 64'(trig_cnt - t0), 64'd11);
    check("lat_trigger_low_at_done", 64'(o_trigger_active), 64'd0);
    @(posedge clk); #1;
    wait_idle();

    // ---- table of single operations ----
    foreach (vecs[k]) begin
      eng_delay = vecs[k].delay;
      i_timeout_cycles = vecs[k].tmo;
      w0 = wait_cnt;
      send(vecs[k].snp, vecs[k].func, vecs[k].addr);
      wait_done($sformatf("vec%0d_done", k));
      check($sformatf("vec%0d_timeout", k), 64'(o_done_timeout), 64'(vecs[k].exp_to));
      check($sformatf("vec%0d_wait_cycles", k), 64'(wait_cnt - w0), 64'(vecs[k].exp_wait));
      check($sformatf("vec%0d_adl", k), 64'(seen_adl), 64'(vecs[k].exp_adl));
      check($sformatf("vec%0d_adt", k), 64'(seen_adt), 64'(vecs[k].exp_adt));
      exp_tcnt += int'(vecs[k].exp_to);
      check($sformatf("vec%0d_tcnt", k), 64'(o_timeout_cnt), 64'(exp_tcnt));
      @(posedge clk); #1;
      wait_idle();
    end
    i_timeout_cycles = '0;

    // ---- fill: engine stalled, 5 requests, 4 accepted ----
    eng_hold = 1'b1; eng_delay = 1;
    @(posedge clk); #1;
    d0 = done_cnt;
    for (int k = 0; k < 4; k++)
      send(1'b0, F_ADT, AW'($urandom_range(0, 32'hFFFF)) << 6);
    i_sw_req_valid = 1'b1; i_sw_func = F_ADL; i_sw_addr = AW'($urandom_range(0, 32'hFFFF)) << 6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_ready_low", 64'(o_sw_req_ready), 64'd0);
    end
    check("full_level", 64'(o_fifo_level), 64'd4);
    @(posedge clk); #1;
    eng_hold = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_sw_req_ready && n < 50);
    check("full_fifth_accept", 64'(o_sw_req_ready), 64'd1);
    check("full_level_after_pop", 64'(o_fifo_level), 64'd3);
    @(posedge clk); #1; i_sw_req_valid = 1'b0;
    n = 0;
    while (done_cnt - d0 < 5 && n < 300) begin @(negedge clk); n++; end
    check("full_all_done", 64'(done_cnt - d0), 64'd5);
    @(posedge clk); #1;
    wait_idle();
    check("full_drained_level", 64'(o_fifo_level), 64'd0);

    // ---- timeout with busy tail: stays in WAIT_IDLE ----
    eng_delay = -1; eng_drain = 5; i_timeout_cycles = 16'd8;
    w0 = wait_cnt;
    send(1'b1, F_ADT, 44'h7_0000);
    wait_done("tmo_done");
    check("tmo_flag", 64'(o_done_timeout), 64'd1);
    check("tmo_wait_cycles", 64'(wait_cnt - w0), 64'd8);
    exp_tcnt++;
    check("tmo_cnt", 64'(o_timeout_cnt), 64'(exp_tcnt));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("tmo_hold_wait_idle", 64'(o_state), 64'd4);
    end
    @(posedge clk); #1;
    wait_idle();
    eng_drain = 0; i_timeout_cycles = '0;

    // ---- contention: both valid, accepts alternate sw/snp ----
    do_reset();
    exp_tcnt = 0;
    eng_delay = 2;
    d0 = done_cnt;
    i_sw_func = F_ADL;  i_sw_addr  = 44'h100;
    i_snp_func = F_ADT; i_snp_addr = 44'h200;
    i_sw_req_valid = 1'b1; i_snp_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!o_sw_req_ready && !o_snp_req_ready && n < 100);
      exp_snp = k[0];
      check("rr_sw_ready", 64'(o_sw_req_ready), 64'(!exp_snp));
      check("rr_snp_ready", 64'(o_snp_req_ready), 64'(exp_snp));
      @(posedge clk); #1;
      if (exp_snp) i_snp_addr = i_snp_addr + 44'h40;
      else         i_sw_addr  = i_sw_addr + 44'h40;
    end
    i_sw_req_valid = 1'b0; i_snp_req_valid = 1'b0;
    n = 0;
    while (done_cnt - d0 < 4 && n < 300) begin @(negedge clk); n++; end
    check("rr_all_done", 64'(done_cnt - d0), 64'd4);
    @(posedge clk); #1;
    wait_idle();

    // ---- reset mid-WAIT_END with two queued ----
    eng_delay = -1; i_timeout_cycles = '0;
    for (int k = 0; k < 3; k++) send(1'b0, F_ADL, AW'(44'h9000 + k * 64));
    n = 0;
    do begin @(negedge clk); n++; end while (o_state != 3'd2 && n < 50);
    check("mid_rst_in_wait_end", 64'(o_state), 64'd2);
    check("mid_rst_level", 64'(o_fifo_level), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_trigger", 64'(o_trigger_active), 64'd0);
    check("mid_rst_adl_en", 64'(o_internal_adl_en), 64'd0);
    check("mid_rst_level0", 64'(o_fifo_level), 64'd0);
    check("mid_rst_state", 64'(o_state), 64'd0);
    check("mid_rst_func_addr", {16'(o_func), 48'(o_addr)}, 64'd0);
    check("mid_rst_done_tcnt", {32'(o_done_valid), 32'(o_timeout_cnt)}, 64'd0);
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
    check("post_rst_idle", {32'(o_state), 32'(o_fifo_level)}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end
endmodule
